// File: rtl/pulse_stretch.sv
// Pulse stretcher: each accepted trigger drives dout high for a programmable
// number of cycles, with optional retrigger and a saturating dropped-trigger count.
module pulse_stretch #(
  parameter int CNT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] len_in,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [7:0]       drop_cnt
);

  // state     | meaning
  // S_IDLE    | output low, waiting for a trigger
  // S_STRETCH | output high, r_cnt holds the remaining high cycles
  typedef enum logic {S_IDLE, S_STRETCH} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_done;
  logic [7:0]       r_drop;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_retrig;

  // A zero length still produces a single high cycle.
  assign w_len_eff = (len_in == '0) ? CNT_W'(1) : len_in;
  assign w_retrig  = (RETRIG != 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pulse_in) begin
            r_state <= S_STRETCH;
            r_cnt   <= w_len_eff;
            r_dout  <= 1'b1;
          end
        end
        S_STRETCH: begin
          if (pulse_in && w_retrig) begin
            r_cnt <= w_len_eff;
          end else begin
            if (pulse_in && (r_drop != 8'hFF))
              r_drop <= r_drop + 8'd1;
            // r_cnt == 1 means this edge closes the last high cycle.
            if (r_cnt == CNT_W'(1)) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_dout  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

  assign dout     = r_dout;
  assign busy     = r_dout;
  assign done     = r_done;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: one instance per retrigger mode, a vector table,
// directed corner sequences and random traffic against a time-based model.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] p;
  logic [7:0] ln [2];
  logic [1:0] dout_v, busy_v, done_v;
  logic [7:0] drop_v [2];

  int checks = 0;
  int failures = 0;
  bit model_en = 1'b0;

  always #5 clk = ~clk;

  pulse_stretch #(.CNT_W(8), .RETRIG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pulse_in(p[0]), .len_in(ln[0]),
    .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .drop_cnt(drop_v[0]));

  pulse_stretch #(.CNT_W(8), .RETRIG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pulse_in(p[1]), .len_in(ln[1]),
    .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .drop_cnt(drop_v[1]));

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a stretch is "active until edge m_end"; dout falls at that edge.
  int t = 0;
  bit m_act [2];
  bit m_done [2];
  int m_end [2];
  int m_drop [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_done[d] = 0; m_end[d] = 0; m_drop[d] = 0;
    end
  end

  always @(posedge clk) begin
    t++;
    for (int d = 0; d < 2; d++) begin
      int len_eff;
      len_eff = (ln[d] == 0) ? 1 : int'(ln[d]);
      if (!rst_n) begin
        m_act[d] = 0; m_done[d] = 0; m_drop[d] = 0;
      end else begin
        m_done[d] = 0;
        if (!m_act[d]) begin
          if (p[d]) begin
            m_act[d] = 1;
            m_end[d] = t + len_eff;
          end
        end else if (p[d] && d == 1) begin
          m_end[d] = t + len_eff;
        end else begin
          if (p[d] && m_drop[d] < 255) m_drop[d]++;
          if (t == m_end[d]) begin
            m_act[d] = 0;
            m_done[d] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model%0d_dout", d), dout_v[d], m_act[d]);
        chk($sformatf("model%0d_busy", d), busy_v[d], m_act[d]);
        chk($sformatf("model%0d_done", d), done_v[d], m_done[d]);
        chk($sformatf("model%0d_drop", d), drop_v[d], m_drop[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d);
    int n;
    p[d] = 1'b0;
    n = 0;
    while ((m_act[d] || m_done[d]) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk($sformatf("idle_timeout%0d", d), 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p = 2'b00;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       pulse;
    logic [7:0] len;
    logic       dout;
    logic       done;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [9:0] pat_dout, pat_done;
    int cnt;

    tbl[0]  = '{1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 8'd5, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0};
    tbl[10] = '{1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 8'd1};
    tbl[13] = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 8'd1};

    rst_n = 1'b0;
    p = 2'b00;
    ln[0] = 8'd0;
    ln[1] = 8'd0;
    tick();
    model_en = 1'b1;

    // Vector table on the drop-mode instance
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n;
      p[0]  = tbl[i].pulse;
      ln[0] = tbl[i].len;
      tick();
      chk($sformatf("tbl%0d_dout", i), dout_v[0], tbl[i].dout);
      chk($sformatf("tbl%0d_busy", i), busy_v[0], tbl[i].dout);
      chk($sformatf("tbl%0d_done", i), done_v[0], tbl[i].done);
      chk($sformatf("tbl%0d_drop", i), drop_v[0], tbl[i].drop);
    end

    // Retrigger: len 4 at N, len 6 at N+3 -> high N+1..N+9, done N+10
    p[1] = 1'b1; ln[1] = 8'd4;
    tick();
    chk("rt_dout_k1", dout_v[1], 1);
    for (int k = 2; k <= 9; k++) begin
      if (k == 4) begin p[1] = 1'b1; ln[1] = 8'd6; end
      else p[1] = 1'b0;
      tick();
      chk($sformatf("rt_dout_k%0d", k), dout_v[1], 1);
      chk($sformatf("rt_done_k%0d", k), done_v[1], 0);
    end
    p[1] = 1'b0;
    tick();
    chk("rt_dout_end", dout_v[1], 0);
    chk("rt_done_end", done_v[1], 1);
    chk("rt_drop", drop_v[1], 0);
    tick();
    chk("rt_done_once", done_v[1], 0);

    // Held input, drop mode, len 3 for 10 edges
    wait_idle(0);
    pat_dout = 10'b1101110111;
    pat_done = 10'b0010001000;
    ln[0] = 8'd3;
    for (int k = 0; k < 10; k++) begin
      p[0] = 1'b1;
      tick();
      chk($sformatf("held_dout_%0d", k + 1), dout_v[0], pat_dout[k]);
      chk($sformatf("held_done_%0d", k + 1), done_v[0], pat_done[k]);
    end
    wait_idle(0);

    // Drops: pulses at N, N+2, N+4 with len 4
    do_reset();
    ln[0] = 8'd4;
    for (int i = 0; i < 5; i++) begin
      p[0] = (i % 2 == 0);
      tick();
      chk($sformatf("drop_dout_%0d", i), dout_v[0], (i < 4) ? 1 : 0);
    end
    chk("drop_done", done_v[0], 1);
    chk("drop_cnt2", drop_v[0], 2);
    p[0] = 1'b0;
    tick();
    chk("drop_after", dout_v[0], 0);

    // Maximum length
    wait_idle(0);
    p[0] = 1'b1; ln[0] = 8'd255;
    tick();
    p[0] = 1'b0;
    cnt = 0;
    while (dout_v[0] && cnt < 300) begin
      cnt++;
      tick();
    end
    chk("max_len_cycles", cnt, 255);
    chk("max_len_done", done_v[0], 1);

    // Saturation under a long held pulse
    wait_idle(0);
    p[0] = 1'b1; ln[0] = 8'd255;
    for (int i = 0; i < 320; i++) tick();
    chk("drop_sat", drop_v[0], 255);
    wait_idle(0);

    // Reset mid-stretch, then trigger on the first released edge
    p[0] = 1'b1; ln[0] = 8'd10;
    tick();
    p[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_dout", dout_v[0], 0);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_drop", drop_v[0], 0);
    rst_n = 1'b1;
    p[0] = 1'b1; ln[0] = 8'd2;
    tick();
    chk("rel_dout", dout_v[0], 1);
    chk("rel_done", done_v[0], 0);
    p[0] = 1'b0;
    tick();
    chk("rel_dout2", dout_v[0], 1);
    tick();
    chk("rel_end_done", done_v[0], 1);
    wait_idle(0);

    // Random traffic on both instances against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int d = 0; d < 2; d++) begin
        p[d] = ($urandom_range(0, 3) == 0);
        ln[d] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      end
      tick();
    end

    model_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter CNT_W, default 8, width of length input and internal counter (2..16).
REQ-002 Parameter RETRIG, default 0: 0 = pulses during a stretch are dropped; 1 = pulses during a stretch restart it.
REQ-003 clk  input  1  rising-edge clock, all logic in this domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pulse_in  input  1  trigger, synchronous to clk; every cycle sampled high is one trigger.
REQ-006 len_in  input  CNT_W  stretch length in cycles, sampled only on an accepted trigger.
REQ-007 dout  output  1  stretched level output, registered.
REQ-008 busy  output  1  high while state is STRETCH; equals dout.
REQ-009 done  output  1  one-cycle pulse marking the end of a stretch, registered.
REQ-010 drop_cnt  output  8  count of dropped triggers, saturating, registered.

Function
REQ-011 Two states: IDLE, STRETCH; a counter of CNT_W bits holds the remaining high cycles.
REQ-012 Effective length L = len_in, except len_in = 0 gives L = 1.
REQ-013 IDLE, pulse_in high at edge N: go to STRETCH, load counter from L; dout high for cycles N+1 .. N+L exactly.
REQ-014 IDLE, pulse_in low: stay IDLE; dout, busy = 0.
REQ-015 STRETCH: counter decrements once per cycle; on the edge ending the last high cycle, go to IDLE and drop dout.
REQ-016 done = 1 for exactly one cycle, the first cycle dout is low after a stretch; never asserted otherwise.
REQ-017 RETRIG=0: pulse_in high in STRETCH, including the last high cycle, is ignored; drop_cnt increments by 1.
REQ-018 drop_cnt saturates at 255; it never wraps.
REQ-019 RETRIG=1: pulse_in high in STRETCH reloads the counter from the current len_in (L rule applies); dout stays high through cycle M+L, where M is the retrigger edge.
REQ-020 RETRIG=1: done fires only at the final end; a retrigger on the last high cycle gives no done and no low gap.
REQ-021 RETRIG=1: drop_cnt stays 0.
REQ-022 pulse_in held high continuously with RETRIG=0: stretches of L cycles, each followed by one low cycle with done=1, then the next stretch.
REQ-023 A trigger in the same cycle that done is high (state IDLE) is accepted normally.
REQ-024 len_in changes during a stretch have no effect unless a retrigger is accepted (RETRIG=1).
REQ-025 Maximum length 2^CNT_W - 1 cycles; no counter overflow for any len_in.

Reset
REQ-026 rst_n low at an edge: state IDLE, counter 0, dout = busy = done = 0, drop_cnt = 0, at that edge.
REQ-027 Reset has priority over every trigger, including mid-stretch; no done is generated for an aborted stretch.
REQ-028 First edge with rst_n high behaves as IDLE; pulse_in high at that edge is accepted.

Verification
REQ-029 Basic, RETRIG=0, CNT_W=8: len_in=5, one-cycle pulse at edge N -> dout high N+1..N+5; done high at N+6 only; drop_cnt=0.
REQ-030 Zero and maximum length: len_in=0 -> dout high one cycle; len_in=255 -> dout high exactly 255 cycles, then done.
REQ-031 Drop, RETRIG=0: len_in=4, pulses at N and N+2 and N+4 -> single stretch N+1..N+4; drop_cnt=2. Then 300 further dropped pulses -> drop_cnt=255.
REQ-032 Retrigger, RETRIG=1: len_in=4, pulse at N, len_in=6 with pulse at N+3 -> dout high N+1..N+9 continuously; one done at N+10; drop_cnt=0.
REQ-033 Held input, RETRIG=0: len_in=3, pulse_in held high 10 cycles from N -> dout high N+1..N+3 and N+5..N+7, low N+4, N+8; done at N+4 and N+8.
REQ-034 Reset mid-stretch: len_in=10, trigger at N, rst_n low at N+4 -> dout, busy 0 from N+4; no done; drop_cnt 0; a trigger at the first edge after reset release starts a new stretch.
